stepper_phase_decoder: RTL and testbench
========================================

// Module: stepper_phase_decoder
// PURPOSE
//  Receive-side counterpart of the wheel stepper drive: watches one 4-bit coil bus (wheel_wires_left or _right).
//  Filters the coil pattern, decodes phase steps into direction and signed position.
//  Flags illegal patterns and skipped phases.
//  Used as on-chip odometry and as a self-check monitor for the motor sequencer in system benches.
// PARAMETERS
//  SETTLE_CYCLES  4     consecutive identical samples required before a pattern is accepted (>=1)
//  POS_W          16    width of signed position counter
//  IDLE_CYCLES    1000  cycles with no accepted step before 'moving' deasserts (>=1)
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous, active-low reset (rst==0 resets on next clk edge)
//  coil_in     in   4      coil drive pattern under observation (asynchronous to clk)
//  pos_clr     in   1      1-cycle pulse: zero position
//  fault_clr   in   1      1-cycle pulse: leave FAULT, return to UNSYNC
//  step_pulse  out  1      1-cycle pulse per accepted phase step
//  step_dir    out  1      direction of last step: 1=forward, 0=reverse
//  position    out  POS_W  signed step count, two's complement
//  moving      out  1      step seen within last IDLE_CYCLES cycles
//  synced      out  1      reference phase established (state TRACK)
//  fault       out  1      sticky fault flag (state FAULT)
//  fault_code  out  2      01=illegal pattern, 10=skipped phase, 00=none
// BEHAVIOUR
//  Reset: all outputs 0; state UNSYNC; sync flops, settle counter, idle counter cleared.
//  Input path: coil_in -> 2-flop synchroniser -> settle filter.
//   Settle counter restarts on any change of the synchronised value.
//   Pattern accepted when stable SETTLE_CYCLES cycles; each stable run is accepted only once.
//  Latency: coil_in change to step_pulse = 2 + SETTLE_CYCLES + 1 clk.
//  Phase map, full-step: 0001=0, 0010=1, 0100=2, 1000=3; modulus M=4.
//  0000 = coils off: legal; no step; reference phase retained.
//  Any other code: illegal.
//  States:
//   UNSYNC: first legal non-zero pattern loads ref phase -> TRACK; no step.
//    Illegal pattern -> FAULT with code 01.
//   TRACK: on accepted non-zero pattern, d = (new - ref) mod M.
//    d=0: nothing.
//    d=1: forward step; position+1; step_dir=1.
//    d=M-1: reverse step; position-1; step_dir=0.
//    Other d: FAULT with code 10.
//    Illegal pattern: FAULT with code 01.
//    ref <= new on every accepted legal non-zero pattern.
//   FAULT: position, step_dir, ref frozen; step_pulse held 0.
//    fault_clr -> UNSYNC with fault=0 and fault_code=00.
//  Position wraps modulo 2^POS_W (0x7FFF+1 -> 0x8000 at POS_W=16); no saturation.
//  pos_clr same cycle as step: position=0, step discarded from count; step_pulse/step_dir still updated.
//  fault_clr same cycle as new fault detection: new fault wins, state stays FAULT with new code.
//  fault_clr outside FAULT: ignored.
//  moving: set on step_pulse; idle counter reset on each step.
//   Cleared when counter reaches IDLE_CYCLES; also cleared on entry to FAULT.
//  Reset asserted mid-operation: full return to reset values on that edge, including position.
// CONFIGURATION
//  HALF_STEP_EN defined: 8-phase half-step map, M=8:
//   0001=0, 0011=1, 0010=2, 0110=3, 0100=4, 1100=5, 1000=6, 1001=7.
//   Each half-step counts +/-1.
//  HALF_STEP_EN undefined: full-step map above; the four 2-coil codes are illegal (code 01).
// TESTING
//  T1 reset: rst=0 two cycles -> all outputs 0, synced=0.
//  T2 forward: drive 0001,0010,0100,1000,0001, each held 8 cycles.
//   -> synced after first; 4 step_pulses; step_dir=1; position=4; moving=1.
//  T3 reverse + wrap (POS_W=4): from position 0, 9 reverse steps -> position=4'b0111 (-9 mod 16); step_dir=0.
//  T4 glitch: pattern 0010 held SETTLE_CYCLES-1 cycles between stable 0001s -> no step_pulse, no fault.
//  T5 faults: 0001 -> 0100 gives fault=1, code=10.
//   fault_clr, then 0101 gives code=01; with HALF_STEP_EN off, 0011 gives code=01.
//   Position frozen while in FAULT.
//  T6 idle/clear: stop after a step -> moving=0 exactly IDLE_CYCLES later.
//   pos_clr coincident with step -> position=0, step_pulse=1.

Source files
------------

// File: rtl/stepper_phase_decoder.sv
// Purpose: decode a 4-bit stepper coil bus into step pulses, direction, position and fault status.
// Latency: coil_in change to step_pulse is 2 (synchroniser) + SETTLE_CYCLES + 1 clk.
// Backpressure: none; observe-only monitor, outputs update every cycle. Define HALF_STEP_EN for the 8-phase map.
module stepper_phase_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int IDLE_CYCLES   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       coil_in,
  input  logic             pos_clr,
  input  logic             fault_clr,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             synced,
  output logic             fault,
  output logic [1:0]       fault_code
);

`ifdef HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IC_W = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {S_UNSYNC, S_TRACK, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1, sync2;
  logic [3:0]        cand;
  logic [SC_W-1:0]   settle_cnt;
  logic              acc_vld;
  logic [PH_W-1:0]   ref_ph, new_ph, delta;
  logic              pat_zero, pat_legal;
  logic              set_fault, load_ref, step_fwd, step_rev;
  logic [1:0]        new_code;
  logic [IC_W-1:0]   idle_cnt;

  // Two-flop synchroniser for the asynchronous coil bus
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= coil_in;
      sync2 <= sync1;
    end
  end

  // Settle filter: count identical samples, fire acc_vld once when a run reaches SETTLE_CYCLES
  always_ff @(posedge clk) begin
    if (!rst) begin
      cand       <= 4'b0000;
      settle_cnt <= '0;
      acc_vld    <= 1'b0;
    end else if (sync2 != cand) begin
      cand       <= sync2;
      settle_cnt <= SC_W'(1);
      acc_vld    <= (SETTLE_CYCLES == 1);
    end else if (settle_cnt < SC_W'(SETTLE_CYCLES)) begin
      settle_cnt <= settle_cnt + SC_W'(1);
      acc_vld    <= ((settle_cnt + SC_W'(1)) == SC_W'(SETTLE_CYCLES));
    end else begin
      acc_vld    <= 1'b0;
    end
  end

  // Map the accepted pattern to a phase and compute its distance from the reference phase
  always_comb begin
    pat_zero  = (cand == 4'b0000);
    pat_legal = 1'b0;
    new_ph    = '0;
    case (cand)
`ifdef HALF_STEP_EN
      4'b0001: begin pat_legal = 1'b1; new_ph = 3'd0; end
      4'b0011: begin pat_legal = 1'b1; new_ph = 3'd1; end
      4'b0010: begin pat_legal = 1'b1; new_ph = 3'd2; end
      4'b0110: begin pat_legal = 1'b1; new_ph = 3'd3; end
      4'b0100: begin pat_legal = 1'b1; new_ph = 3'd4; end
      4'b1100: begin pat_legal = 1'b1; new_ph = 3'd5; end
      4'b1000: begin pat_legal = 1'b1; new_ph = 3'd6; end
      4'b1001: begin pat_legal = 1'b1; new_ph = 3'd7; end
`else
      4'b0001: begin pat_legal = 1'b1; new_ph = 2'd0; end
      4'b0010: begin pat_legal = 1'b1; new_ph = 2'd1; end
      4'b0100: begin pat_legal = 1'b1; new_ph = 2'd2; end
      4'b1000: begin pat_legal = 1'b1; new_ph = 2'd3; end
`endif
      default: begin pat_legal = 1'b0; new_ph = '0; end
    endcase
    // Modulus is a power of two, so natural wrap of PH_W bits gives (new - ref) mod M
    delta = new_ph - ref_ph;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_UNSYNC;
    else      state_q <= state_d;
  end

  // Next-state and step/fault event decode; a pattern arriving with fault_clr is judged as in UNSYNC
  always_comb begin
    state_d   = state_q;
    set_fault = 1'b0;
    new_code  = 2'b00;
    load_ref  = 1'b0;
    step_fwd  = 1'b0;
    step_rev  = 1'b0;
    if (state_q == S_FAULT && fault_clr) state_d = S_UNSYNC;
    if (acc_vld && !pat_zero) begin
      if (state_q == S_TRACK) begin
        if (!pat_legal) begin
          set_fault = 1'b1;
          new_code  = 2'b01;
        end else if (delta == PH_W'(1)) begin
          step_fwd = 1'b1;
          load_ref = 1'b1;
        end else if (delta == '1) begin
          step_rev = 1'b1;
          load_ref = 1'b1;
        end else if (delta != '0) begin
          set_fault = 1'b1;
          new_code  = 2'b10;
        end else begin
          load_ref = 1'b1;
        end
      end else if (state_q == S_UNSYNC || fault_clr) begin
        if (!pat_legal) begin
          set_fault = 1'b1;
          new_code  = 2'b01;
        end else begin
          load_ref = 1'b1;
          state_d  = S_TRACK;
        end
      end
    end
    if (set_fault) state_d = S_FAULT;
  end

  // Status outputs decoded straight from state
  always_comb begin
    synced = (state_q == S_TRACK);
    fault  = (state_q == S_FAULT);
  end

  // Step pulse, direction, reference phase and fault code
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      ref_ph     <= '0;
      fault_code <= 2'b00;
    end else begin
      step_pulse <= step_fwd | step_rev;
      if (step_fwd | step_rev) step_dir <= step_fwd;
      if (load_ref) ref_ph <= new_ph;
      if (set_fault)                                      fault_code <= new_code;
      else if (state_q == S_FAULT && state_d == S_UNSYNC) fault_code <= 2'b00;
    end
  end

  // Position counter; pos_clr overrides a same-cycle step, wraps freely otherwise
  always_ff @(posedge clk) begin
    if (!rst)          position <= '0;
    else if (pos_clr)  position <= '0;
    else if (step_fwd) position <= position + POS_W'(1);
    else if (step_rev) position <= position - POS_W'(1);
  end

  // Motion indicator: re-armed by each step, drops IDLE_CYCLES later or on fault entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      moving   <= 1'b0;
      idle_cnt <= '0;
    end else if (set_fault) begin
      moving   <= 1'b0;
      idle_cnt <= '0;
    end else if (step_fwd | step_rev) begin
      moving   <= 1'b1;
      idle_cnt <= '0;
    end else if (moving) begin
      if (idle_cnt == IC_W'(IDLE_CYCLES - 1)) begin
        moving   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Purpose: scoreboard bench for stepper_phase_decoder (full-step build, POS_W=4).
// Latency: expects step_pulse 2+SETTLE+1 clk after each coil change.
// Backpressure: none; monitor pops expected steps/faults whenever the DUT reports one.
module tb_stepper_phase_decoder;
  localparam int SETTLE = 4;
  localparam int POS_W  = 4;
  localparam int IDLE   = 40;
  localparam int LAT    = 2 + SETTLE + 1;

  typedef struct packed {
    logic             dir;
    logic [POS_W-1:0] pos;
  } step_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       coil_in;
  logic             pos_clr;
  logic             fault_clr;
  logic             step_pulse;
  logic             step_dir;
  logic [POS_W-1:0] position;
  logic             moving;
  logic             synced;
  logic             fault;
  logic [1:0]       fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  step_exp_t  step_q[$];
  logic [1:0] fault_q[$];
  step_exp_t  mon_e;
  logic [1:0] mon_code;
  logic       fault_prev = 1'b0;

  logic [3:0] fwd_pat [4];
  logic [3:0] rev_pat [4];

  always #5 clk = ~clk;

  stepper_phase_decoder #(
    .SETTLE_CYCLES(SETTLE),
    .POS_W        (POS_W),
    .IDLE_CYCLES  (IDLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coil_in   (coil_in),
    .pos_clr   (pos_clr),
    .fault_clr (fault_clr),
    .step_pulse(step_pulse),
    .step_dir  (step_dir),
    .position  (position),
    .moving    (moving),
    .synced    (synced),
    .fault     (fault),
    .fault_code(fault_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_step(input logic dir, input logic [POS_W-1:0] pos);
    step_exp_t e;
    e.dir = dir;
    e.pos = pos;
    step_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    coil_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fault_clr();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  // Monitor: compare every reported step and every new fault against the scoreboard queues
  always @(negedge clk) begin
    if (step_pulse) begin
      if (step_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_step: got dir=%0b pos=%0h, expected no step (t=%0t)", step_dir, position, $time);
      end else begin
        mon_e = step_q.pop_front();
        chk("step_dir", {31'd0, step_dir}, {31'd0, mon_e.dir});
        chk("step_pos", {28'd0, position}, {28'd0, mon_e.pos});
      end
    end
    if (fault && !fault_prev) begin
      if (fault_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_fault: got code=%0b, expected no fault (t=%0t)", fault_code, $time);
      end else begin
        mon_code = fault_q.pop_front();
        chk("fault_code_evt", {30'd0, fault_code}, {30'd0, mon_code});
      end
    end
    fault_prev = fault;
  end

  initial begin
    fwd_pat[0] = 4'b0010; fwd_pat[1] = 4'b0100; fwd_pat[2] = 4'b1000; fwd_pat[3] = 4'b0001;
    rev_pat[0] = 4'b1000; rev_pat[1] = 4'b0100; rev_pat[2] = 4'b0010; rev_pat[3] = 4'b0001;
    rst = 1'b0; coil_in = 4'b0000; pos_clr = 1'b0; fault_clr = 1'b0;

    // T1 reset
    repeat (2) @(negedge clk);
    chk("rst_step_pulse", {31'd0, step_pulse}, 0);
    chk("rst_step_dir",   {31'd0, step_dir}, 0);
    chk("rst_position",   {28'd0, position}, 0);
    chk("rst_moving",     {31'd0, moving}, 0);
    chk("rst_synced",     {31'd0, synced}, 0);
    chk("rst_fault",      {31'd0, fault}, 0);
    chk("rst_fault_code", {30'd0, fault_code}, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // T2 forward: first pattern syncs, four steps follow
    hold(4'b0001, 8);
    chk("t2_synced", {31'd0, synced}, 1);
    for (int i = 0; i < 4; i++) begin
      push_step(1'b1, 4'(i + 1));
      hold(fwd_pat[i], 8);
    end
    chk("t2_position", {28'd0, position}, 4);
    chk("t2_dir",      {31'd0, step_dir}, 1);
    chk("t2_moving",   {31'd0, moving}, 1);

    // T3 reverse with wrap: nine reverse steps from zero
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    chk("t3_pos_clr", {28'd0, position}, 0);
    for (int i = 0; i < 9; i++) begin
      push_step(1'b0, 4'(15 - i));
      hold(rev_pat[i % 4], 8);
    end
    chk("t3_position", {28'd0, position}, 4'b0111);
    chk("t3_dir",      {31'd0, step_dir}, 0);

    // T4 forward across the signed boundary 0111 -> 1000, then a short glitch
    push_step(1'b1, 4'b1000);
    hold(4'b0001, 8);
    hold(4'b0010, SETTLE - 1);
    hold(4'b0001, 12);
    chk("t4_fault",    {31'd0, fault}, 0);
    chk("t4_position", {28'd0, position}, 4'b1000);

    // T5 faults: skipped phase, then illegal patterns
    fault_q.push_back(2'b10);
    hold(4'b0100, 8);
    chk("t5_fault",   {31'd0, fault}, 1);
    chk("t5_code10",  {30'd0, fault_code}, 2'b10);
    chk("t5_synced",  {31'd0, synced}, 0);
    chk("t5_moving",  {31'd0, moving}, 0);
    hold(4'b1000, 8);
    chk("t5_pos_frozen", {28'd0, position}, 4'b1000);
    pulse_fault_clr();
    chk("t5_clr_fault", {31'd0, fault}, 0);
    chk("t5_clr_code",  {30'd0, fault_code}, 0);
    fault_q.push_back(2'b01);
    hold(4'b0101, 8);
    chk("t5_code01_a", {30'd0, fault_code}, 2'b01);
    pulse_fault_clr();
    fault_q.push_back(2'b01);
    hold(4'b0011, 8);
    chk("t5_code01_b", {30'd0, fault_code}, 2'b01);
    chk("t5_pos_frozen2", {28'd0, position}, 4'b1000);
    pulse_fault_clr();
    hold(4'b0001, 8);
    chk("t5_resync", {31'd0, synced}, 1);

    // T6 idle timeout: moving drops exactly IDLE cycles after the step
    push_step(1'b1, 4'd9);
    coil_in = 4'b0010;
    repeat (LAT + IDLE - 1) @(negedge clk);
    chk("t6_moving_before", {31'd0, moving}, 1);
    @(negedge clk);
    chk("t6_moving_after",  {31'd0, moving}, 0);
    chk("t6_position",      {28'd0, position}, 9);

    // T6 pos_clr coincident with a step
    push_step(1'b1, 4'd0);
    coil_in = 4'b0100;
    repeat (LAT - 1) @(negedge clk);
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_pos_clr_step", {28'd0, position}, 0);
    chk("t6_moving_step",  {31'd0, moving}, 1);

    // Reset mid-operation
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dir",    {31'd0, step_dir}, 0);
    chk("mid_rst_synced", {31'd0, synced}, 0);
    chk("mid_rst_moving", {31'd0, moving}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("step_q_drained",  step_q.size(), 0);
    chk("fault_q_drained", fault_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
